// File: rtl/fme_sad_accum.sv
// Nine-candidate SAD accumulator for fractional motion estimation; pulses en with final distortions.
// Optional MV-cost bias preload of the eight sub-pel candidates is enabled by defining FME_SAD_MVCOST_EN.
module fme_sad_accum #(
    parameter int NPIX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef FME_SAD_MVCOST_EN
    input  logic [15:0]      mv_cost,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       cur_pix,
    input  logic [8:0][7:0]  ref_pix,
    output logic             busy,
    output logic             en,
    output logic [8:0][15:0] distort
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [8:0] LAST_CNT = 9'(NPIX - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [8:0]       r_cnt;
    logic [8:0][15:0] r_distort;
    logic [8:0][15:0] w_init;
    logic             w_start_acc;
    logic             w_beat;
    logic             w_last;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? 8'(-d) : 8'(d);
    endfunction

    // 17-bit sum clamps at full scale so a long or biased block never wraps.
    function automatic logic [15:0] sat_add(input logic [15:0] acc, input logic [7:0] inc);
        logic [16:0] s;
        s = {1'b0, acc} + {9'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign w_start_acc = start && (r_state == S_IDLE);
    assign w_beat      = in_valid && (r_state == S_ACCUM);
    assign w_last      = w_beat && (r_cnt == LAST_CNT);

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        en          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                busy        = 1'b1;
                en          = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Centre candidate has zero MV offset, so it never carries the bias.
    always_comb begin
        w_init = '0;
`ifdef FME_SAD_MVCOST_EN
        for (int k = 0; k < 8; k++) w_init[k] = mv_cost;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 9'd0;
            r_distort <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_cnt     <= 9'd0;
                r_distort <= w_init;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 9'd1;
                for (int k = 0; k < 9; k++)
                    r_distort[k] <= sat_add(r_distort[k], abs_diff(cur_pix, ref_pix[k]));
            end
        end
    end

    assign distort = r_distort;

endmodule

// File: tb/tb_fme_sad_accum.sv
// Scoreboard bench for fme_sad_accum: three instances (NPIX = 16, 1, 256) share the pixel bus.
module tb_fme_sad_accum;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       cur_pix = 8'd0;
    logic [8:0][7:0]  ref_pix = '0;
`ifdef FME_SAD_MVCOST_EN
    logic [15:0]      mv_cost = 16'd0;
`endif
    logic             rdy_a, busy_a, en_a;
    logic             rdy_b, busy_b, en_b;
    logic             rdy_c, busy_c, en_c;
    logic [8:0][15:0] dist_a, dist_b, dist_c;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int en_cnt_a = 0, en_cnt_b = 0, en_cnt_c = 0;
    logic [8:0][15:0] sb_q[$];

    fme_sad_accum #(.NPIX(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
`ifdef FME_SAD_MVCOST_EN
        .mv_cost(mv_cost),
`endif
        .in_valid(in_valid), .in_ready(rdy_a), .cur_pix(cur_pix), .ref_pix(ref_pix),
        .busy(busy_a), .en(en_a), .distort(dist_a));

    fme_sad_accum #(.NPIX(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
`ifdef FME_SAD_MVCOST_EN
        .mv_cost(mv_cost),
`endif
        .in_valid(in_valid), .in_ready(rdy_b), .cur_pix(cur_pix), .ref_pix(ref_pix),
        .busy(busy_b), .en(en_b), .distort(dist_b));

    fme_sad_accum #(.NPIX(256)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c),
`ifdef FME_SAD_MVCOST_EN
        .mv_cost(mv_cost),
`endif
        .in_valid(in_valid), .in_ready(rdy_c), .cur_pix(cur_pix), .ref_pix(ref_pix),
        .busy(busy_c), .en(en_c), .distort(dist_c));

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (en_a === 1'b1) en_cnt_a++;
        if (en_b === 1'b1) en_cnt_b++;
        if (en_c === 1'b1) en_cnt_c++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] acc_model(input logic [15:0] acc, input int c, input int r);
        int s;
        s = int'(acc) + ((c > r) ? (c - r) : (r - c));
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({en_a, busy_a, rdy_a, en_b, busy_b, rdy_b, en_c, busy_c, rdy_c} !== 9'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {en_a, busy_a, rdy_a, en_b, busy_b, rdy_b, en_c, busy_c, rdy_c});
        end
        checks++;
        if (dist_a !== '0) begin failures++; $display("FAIL reset_dist_a got=%h exp=0", dist_a); end
        checks++;
        if (dist_b !== '0) begin failures++; $display("FAIL reset_dist_b got=%h exp=0", dist_b); end
        checks++;
        if (dist_c !== '0) begin failures++; $display("FAIL reset_dist_c got=%h exp=0", dist_c); end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_ramp;
        logic [8:0][15:0] e, got;
        int ts, lat, en0, best;
        e = '0;
        for (int j = 0; j < 16; j++)
            for (int k = 0; k < 9; k++) e[k] = acc_model(e[k], 100, 100 + k);
        sb_q.push_back(e);
        en0 = en_cnt_a;
        start_a = 1'b1; tick; start_a = 1'b0; ts = cyc;
        @(negedge clk);
        checks++;
        if ({busy_a, rdy_a} !== 2'b11) begin failures++; $display("FAIL ramp_busy got=%b exp=11", {busy_a, rdy_a}); end
        for (int j = 0; j < 16; j++) begin
            in_valid = 1'b1; cur_pix = 8'd100;
            for (int k = 0; k < 9; k++) ref_pix[k] = 8'(100 + k);
            tick;
        end
        in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (en_a === 1'b1) begin lat = cyc - ts; break; end
        end
        checks++;
        if (lat != 16) begin failures++; $display("FAIL ramp_latency got=%0d exp=16", lat); end
        got = dist_a;
        e = sb_q.pop_front();
        checks++;
        if (got !== e) begin failures++; $display("FAIL ramp_distort got=%h exp=%h", got, e); end
        best = 0;
        for (int k = 1; k < 9; k++) if (got[k] < got[best]) best = k;
        checks++;
        if (best != 0) begin failures++; $display("FAIL ramp_best got=%0d exp=0", best); end
        @(negedge clk);
        checks++;
        if ({en_a, busy_a, rdy_a} !== 3'b000) begin failures++; $display("FAIL ramp_idle got=%b exp=000", {en_a, busy_a, rdy_a}); end
        checks++;
        if (dist_a !== e) begin failures++; $display("FAIL ramp_hold got=%h exp=%h", dist_a, e); end
        tick;
        checks++;
        if (en_cnt_a - en0 != 1) begin failures++; $display("FAIL ramp_en_count got=%0d exp=1", en_cnt_a - en0); end
    endtask

    task automatic test_bubbles;
        logic [8:0][15:0] e;
        int ts, lat, en0;
        e = '0;
        for (int j = 0; j < 16; j++)
            for (int k = 0; k < 9; k++) e[k] = acc_model(e[k], 10, (k < 4) ? 15 : 5);
        sb_q.push_back(e);
        en0 = en_cnt_a;
        start_a = 1'b1; tick; start_a = 1'b0; ts = cyc;
        for (int j = 0; j < 16; j++) begin
            in_valid = 1'b0; tick;
            in_valid = 1'b1; cur_pix = 8'd10;
            for (int k = 0; k < 9; k++) ref_pix[k] = (k < 4) ? 8'd15 : 8'd5;
            tick;
        end
        in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (en_a === 1'b1) begin lat = cyc - ts; break; end
        end
        checks++;
        if (lat != 32) begin failures++; $display("FAIL bubble_latency got=%0d exp=32", lat); end
        e = sb_q.pop_front();
        checks++;
        if (dist_a !== e) begin failures++; $display("FAIL bubble_distort got=%h exp=%h", dist_a, e); end
        tick;
        checks++;
        if (en_cnt_a - en0 != 1) begin failures++; $display("FAIL bubble_en_count got=%0d exp=1", en_cnt_a - en0); end
    endtask

    task automatic test_ignored;
        logic [8:0][15:0] e;
        int ts, lat, en0;
        e = '0;
        for (int j = 0; j < 16; j++)
            for (int k = 0; k < 9; k++) e[k] = acc_model(e[k], 8 * j, 50 + 10 * k);
        sb_q.push_back(e);
        en0 = en_cnt_a;
        start_a = 1'b1; tick; start_a = 1'b0; ts = cyc;
        for (int j = 0; j < 16; j++) begin
            in_valid = 1'b1; cur_pix = 8'(8 * j);
            for (int k = 0; k < 9; k++) ref_pix[k] = 8'(50 + 10 * k);
            start_a = (j == 7);
            tick;
            start_a = 1'b0;
        end
        in_valid = 1'b0;
        @(negedge clk);
        lat = cyc - ts;
        checks++;
        if (en_a !== 1'b1 || lat != 16) begin
            failures++; $display("FAIL ignored_en got=%b@%0d exp=1@16", en_a, lat);
        end
        e = sb_q.pop_front();
        checks++;
        if (dist_a !== e) begin failures++; $display("FAIL ignored_distort got=%h exp=%h", dist_a, e); end
        start_a = 1'b1; tick; start_a = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0) begin failures++; $display("FAIL ignored_done_start got=%b exp=0", busy_a); end
        in_valid = 1'b1; cur_pix = 8'd0;
        for (int k = 0; k < 9; k++) ref_pix[k] = 8'd255;
        tick; tick; tick;
        in_valid = 1'b0;
        checks++;
        if (dist_a !== e) begin failures++; $display("FAIL ignored_idle_hold got=%h exp=%h", dist_a, e); end
        checks++;
        if (en_cnt_a - en0 != 1) begin failures++; $display("FAIL ignored_en_count got=%0d exp=1", en_cnt_a - en0); end
    endtask

    task automatic test_reset_mid;
        logic [8:0][15:0] e;
        int ts, lat, en0;
        start_a = 1'b1; tick; start_a = 1'b0;
        for (int j = 0; j < 7; j++) begin
            in_valid = 1'b1; cur_pix = 8'd50;
            for (int k = 0; k < 9; k++) ref_pix[k] = 8'd60;
            tick;
        end
        in_valid = 1'b0;
        en0 = en_cnt_a;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({en_a, busy_a, rdy_a} !== 3'b000) begin failures++; $display("FAIL rstmid_ctrl got=%b exp=000", {en_a, busy_a, rdy_a}); end
        checks++;
        if (dist_a !== '0) begin failures++; $display("FAIL rstmid_dist got=%h exp=0", dist_a); end
        @(negedge clk);
        rst_n = 1'b1;
        tick; tick; tick;
        checks++;
        if (en_cnt_a != en0 || busy_a !== 1'b0) begin
            failures++; $display("FAIL rstmid_no_en got=%0d/%b exp=0/0", en_cnt_a - en0, busy_a);
        end
        e = '0;
        for (int j = 0; j < 16; j++)
            for (int k = 0; k < 9; k++) e[k] = acc_model(e[k], 200, 200 - 3 * k);
        sb_q.push_back(e);
        start_a = 1'b1; tick; start_a = 1'b0; ts = cyc;
        for (int j = 0; j < 16; j++) begin
            in_valid = 1'b1; cur_pix = 8'd200;
            for (int k = 0; k < 9; k++) ref_pix[k] = 8'(200 - 3 * k);
            tick;
        end
        in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (en_a === 1'b1) begin lat = cyc - ts; break; end
        end
        checks++;
        if (lat != 16) begin failures++; $display("FAIL rstmid_latency got=%0d exp=16", lat); end
        e = sb_q.pop_front();
        checks++;
        if (dist_a !== e) begin failures++; $display("FAIL rstmid_distort got=%h exp=%h", dist_a, e); end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [8:0][15:0] e;
        int ts, lat;
        for (int job = 0; job < 2; job++) begin
            e = '0;
            for (int k = 0; k < 9; k++) e[k] = acc_model(e[k], 7 * job, (job == 0) ? 30 * k : 20 * k + 1);
            sb_q.push_back(e);
            start_b = 1'b1; tick; start_b = 1'b0; ts = cyc;
            in_valid = 1'b1; cur_pix = 8'(7 * job);
            for (int k = 0; k < 9; k++) ref_pix[k] = (job == 0) ? 8'(30 * k) : 8'(20 * k + 1);
            tick;
            in_valid = 1'b0;
            lat = -1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (en_b === 1'b1) begin lat = cyc - ts; break; end
            end
            checks++;
            if (lat != 1) begin failures++; $display("FAIL npix1_latency job=%0d got=%0d exp=1", job, lat); end
            e = sb_q.pop_front();
            checks++;
            if (dist_b !== e) begin failures++; $display("FAIL npix1_distort job=%0d got=%h exp=%h", job, dist_b, e); end
            tick;
        end
    endtask

    task automatic test_npix256;
        logic [8:0][15:0] e;
        int ts, lat;
        e = '0;
        for (int j = 0; j < 256; j++)
            for (int k = 0; k < 9; k++) e[k] = acc_model(e[k], 0, 255);
        sb_q.push_back(e);
        start_c = 1'b1; tick; start_c = 1'b0; ts = cyc;
        for (int j = 0; j < 256; j++) begin
            in_valid = 1'b1; cur_pix = 8'd0;
            for (int k = 0; k < 9; k++) ref_pix[k] = 8'd255;
            tick;
        end
        in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (en_c === 1'b1) begin lat = cyc - ts; break; end
        end
        checks++;
        if (lat != 256) begin failures++; $display("FAIL npix256_latency got=%0d exp=256", lat); end
        e = sb_q.pop_front();
        checks++;
        if (dist_c !== e) begin failures++; $display("FAIL npix256_distort got=%h exp=%h", dist_c, e); end
        tick;
    endtask

`ifdef FME_SAD_MVCOST_EN
    task automatic test_saturation;
        logic [8:0][15:0] e;
        int ts, lat;
        for (int k = 0; k < 9; k++) e[k] = (k < 8) ? 16'hFFF0 : 16'd0;
        for (int j = 0; j < 16; j++)
            for (int k = 0; k < 9; k++) e[k] = acc_model(e[k], 255, 0);
        sb_q.push_back(e);
        mv_cost = 16'hFFF0;
        start_a = 1'b1; tick; start_a = 1'b0; ts = cyc;
        mv_cost = 16'd0;
        for (int j = 0; j < 16; j++) begin
            in_valid = 1'b1; cur_pix = 8'd255;
            for (int k = 0; k < 9; k++) ref_pix[k] = 8'd0;
            tick;
        end
        in_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (en_a === 1'b1) begin lat = cyc - ts; break; end
        end
        checks++;
        if (lat != 16) begin failures++; $display("FAIL sat_latency got=%0d exp=16", lat); end
        e = sb_q.pop_front();
        checks++;
        if (dist_a !== e) begin failures++; $display("FAIL sat_distort got=%h exp=%h", dist_a, e); end
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_ramp;
        test_bubbles;
        test_ignored;
        test_reset_mid;
        test_back_to_back;
        test_npix256;
`ifdef FME_SAD_MVCOST_EN
        test_saturation;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fme_sad_accum.md
# fme_sad_accum

Distortion producer for the fractional motion estimation (FME) stage. It streams one block's current pixels against the nine interpolated candidate positions (eight sub-pel neighbours plus the centre, index 8) and accumulates one SAD per candidate. When the block is complete it pulses `en` with the nine 16-bit distortions stable on `distort`. Those two outputs drive the comparator's `en`/`distort` inputs directly.

## Interface
- `NPIX`, default 16: pixels per block (beats per job); legal range 1..256.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle job request; honoured only in IDLE.
- `mv_cost`  in  16  MV cost bias, sampled on an accepted `start`. Port exists only with `FME_SAD_MVCOST_EN`.
- `in_valid`  in  1  the pixel beat is valid.
- `in_ready`  out  1  the block accepts a beat this cycle.
- `cur_pix`  in  8  current-block pixel, unsigned.
- `ref_pix`  in  [8:0][7:0]  co-located pixel for candidates 0..8, unsigned.
- `busy`  out  1  high in ACCUM and DONE.
- `en`  out  1  one-cycle pulse: `distort` is final.
- `distort`  out  [8:0][15:0]  per-candidate SAD, registered.

## Operation
- States and transitions:
  - IDLE: `start` goes to ACCUM.
  - ACCUM: the NPIX-th accepted beat goes to DONE.
  - DONE: goes to IDLE unconditionally.
- On an accepted `start`:
  - the beat counter clears;
  - `distort[k]` loads its initial value (0, or the bias under `FME_SAD_MVCOST_EN`).
- Beat acceptance:
  - a beat is accepted when `in_valid && in_ready`;
  - `in_ready` is 1 only in ACCUM;
  - each accepted beat adds |`cur_pix` − `ref_pix[k]`| (8-bit) to `distort[k]` for all k in parallel.
- Arithmetic: each sum is computed 17 bits wide and saturates to 16'hFFFF. Accumulators never wrap.
- Counter: 9 bits, counts accepted beats. The terminal condition is count == NPIX−1 together with an accepted beat.
- DONE: `en` = 1 for exactly this one cycle and `in_ready` = 0.
- Hold: `distort` holds its value after DONE until the next accepted `start`, so it stays stable for the comparator's `best <= h` capture.
- Ignored inputs:
  - `start` in ACCUM or DONE is ignored; there is no restart.
  - `in_valid` outside ACCUM is ignored.
- Bubbles: gaps in `in_valid` stall accumulation with no state loss.
- Reset values: state = IDLE, `en` = 0, `busy` = 0, `in_ready` = 0, every `distort[k]` = 0, count = 0.
- Reset mid-job: the partial sums are discarded and no `en` is produced.

## Timing
- `start` high in cycle T (IDLE): `busy` and `in_ready` are 1 from T+1.
- Last beat accepted in cycle L:
  - `distort` is final and `en` = 1 in cycle L+1;
  - `in_ready` = 0 in cycle L+1;
  - the block is in IDLE at L+2.
- With continuous `in_valid` from T+1: `en` occurs at T+NPIX+1. Per-job occupancy is NPIX+2 cycles.
- The comparator registers `best` and raises `done` at L+2.
- `start` high in cycle L+1 (DONE) is ignored. The earliest next job starts from `start` in cycle L+2.

## Configuration
- `FME_SAD_MVCOST_EN` defined:
  - the `mv_cost` port exists;
  - on an accepted `start`, `distort[0..7]` load `mv_cost` and `distort[8]` (centre, zero MV offset) loads 0;
  - accumulation still saturates.
- `FME_SAD_MVCOST_EN` undefined:
  - the port is absent;
  - all nine accumulators load 0 on `start`.

## Test plan
- Ramp SAD:
  - setup: NPIX=16; `start` then 16 back-to-back beats, `cur_pix`=100, `ref_pix[k]`=100+k;
  - expected: `distort[k]`=16·k, single `en` pulse at T+17, a downstream comparator yields best=0.
- Abs-diff sign and bubbles:
  - setup: `cur_pix`=10, `ref_pix[k]`=10+(k<4 ? 5 : −5), 16 beats with `in_valid` low on every other cycle;
  - expected: every `distort[k]`=80, `en` exactly one cycle after the 16th accepted beat, and no count advance while `in_valid`=0.
- Saturation and bias:
  - setup: `FME_SAD_MVCOST_EN`, `mv_cost`=16'hFFF0, |diff|=255 on all candidates;
  - expected: `distort[0..7]`=16'hFFFF, `distort[8]`=16·255=4080.
- Ignored inputs:
  - stimulus: `start` pulsed mid-ACCUM and again in the DONE cycle, plus `in_valid` in IDLE;
  - expected: the job completes unaffected with one `en`, and `distort` is unchanged in IDLE.
- Reset mid-job:
  - stimulus: `rst_n` low after 7 beats, then released;
  - expected: all outputs are 0 and state is IDLE, no `en` is produced, and a fresh job then gives correct sums.
- Boundary NPIX:
  - stimulus: NPIX=1, and NPIX=256 with |diff|=255;
  - expected: `en` at T+2 for NPIX=1; `distort`=65280 (unsaturated) for NPIX=256.
